// File: rtl/spi_pkg.sv
// Shared defaults, FSM state encoding and store-depth helper for the SPI slave.
package spi_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Without the FIFO option the receive store collapses to one holding register.
  function automatic int store_depth(input bit fifo_en, input int fifo_depth);
    return fifo_en ? fifo_depth : 1;
  endfunction

endpackage

// File: rtl/spi_slv_rxfifo.sv
// Receive store for the SPI slave: single holding register at DEPTH 1,
// otherwise a power-of-two FIFO with wrap-around pointers.
module spi_slv_rxfifo
  import spi_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  generate
    if (DEPTH == 1) begin : g_hold
      logic [DATA_W-1:0] r_data;
      logic              r_valid;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_data  <= '0;
          r_valid <= 1'b0;
        end else if (push && (!r_valid || pop)) begin
          r_data  <= din;
          r_valid <= 1'b1;
        end else if (pop && r_valid) begin
          r_valid <= 1'b0;
        end
      end

      assign full  = r_valid;
      assign empty = !r_valid;
      assign dout  = r_valid ? r_data : '0;
    end else begin : g_fifo
      localparam int PTR_W = $clog2(DEPTH);
      localparam int CNT_W = PTR_W + 1;

      logic [DATA_W-1:0] r_mem [DEPTH];
      logic [PTR_W-1:0]  r_wr_ptr;
      logic [PTR_W-1:0]  r_rd_ptr;
      logic [CNT_W-1:0]  r_count;
      logic              w_full;
      logic              w_empty;
      logic              w_do_pop;
      logic              w_do_push;

      assign w_full    = (r_count == CNT_W'(DEPTH));
      assign w_empty   = (r_count == '0);
      assign w_do_pop  = pop && !w_empty;
      // A pop in the same cycle frees the slot the incoming byte needs.
      assign w_do_push = push && (!w_full || w_do_pop);

      always_ff @(posedge clk) begin
        if (w_do_push) begin
          r_mem[r_wr_ptr] <= din;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end else begin
          if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
          if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
          case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
          endcase
        end
      end

      assign full  = w_full;
      assign empty = w_empty;
      assign dout  = w_empty ? '0 : r_mem[r_rd_ptr];
    end
  endgenerate

endmodule

// File: rtl/spi_slave_fsm.sv
// SPI slave clocked by the system clock: MSB-first receive into a store, reply shifted on miso.
// Define SPI_SLV_FIFO_EN to use a FIFO_DEPTH-entry receive FIFO instead of a holding register.
module spi_slave_fsm
  import spi_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              busy,
  output logic              overflow,
  output logic              frame_err
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
`ifdef SPI_SLV_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif
  localparam int STORE_DEPTH = store_depth(FIFO_EN, FIFO_DEPTH);

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [CNT_W-1:0]  w_bit_cnt_next;
  logic [DATA_W-1:0] r_rx_shift;
  logic [DATA_W-1:0] w_rx_shift_next;
  logic [DATA_W-1:0] r_tx_shift;
  logic [DATA_W-1:0] w_tx_shift_next;
  logic              r_miso;
  logic              r_overflow;
  logic              r_frame_err;

  logic              w_sample;
  logic              w_byte_done;
  logic              w_frame_err;
  logic [DATA_W-1:0] w_byte;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_overflow;
  logic [DATA_W-1:0] w_dout;

  assign w_byte = {r_rx_shift[DATA_W-2:0], mosi};

  always_comb begin
    w_state_next    = r_state;
    w_bit_cnt_next  = r_bit_cnt;
    w_rx_shift_next = r_rx_shift;
    w_tx_shift_next = r_tx_shift;
    w_sample        = 1'b0;
    w_byte_done     = 1'b0;
    w_frame_err     = 1'b0;

    case (r_state)
      IDLE: begin
        if (!ss) begin
          w_state_next = SHIFT;
          w_sample     = 1'b1;
        end
      end
      SHIFT: begin
        if (!ss) begin
          w_sample = 1'b1;
        end else begin
          w_state_next    = IDLE;
          w_bit_cnt_next  = '0;
          w_rx_shift_next = '0;
          if (r_bit_cnt != '0) begin
            w_frame_err     = 1'b1;
            w_tx_shift_next = '0;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    if (w_sample) begin
      w_rx_shift_next = w_byte;
      w_tx_shift_next = {r_tx_shift[DATA_W-2:0], 1'b0};
      if (r_bit_cnt == LAST_BIT) begin
        w_byte_done    = 1'b1;
        w_bit_cnt_next = '0;
        // Clear so an unloaded follow-on byte goes out as all zeros.
        w_tx_shift_next = '0;
      end else begin
        w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
      end
    end

    // A reply accepted in IDLE replaces whatever is left in the shifter.
    if (r_state == IDLE && tx_valid) begin
      w_tx_shift_next = tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_rx_shift  <= '0;
      r_tx_shift  <= '0;
      r_miso      <= 1'b0;
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_rx_shift  <= w_rx_shift_next;
      r_tx_shift  <= w_tx_shift_next;
      r_miso      <= w_tx_shift_next[DATA_W-1];
      r_overflow  <= r_overflow | w_overflow;
      r_frame_err <= w_frame_err;
    end
  end

  // Pop is evaluated before push so a full store can accept on a same-cycle read.
  assign w_pop      = !w_empty && rx_ready;
  assign w_push     = w_byte_done && (!w_full || w_pop);
  assign w_overflow = w_byte_done && w_full && !w_pop;

  spi_slv_rxfifo #(
    .DATA_W (DATA_W),
    .DEPTH  (STORE_DEPTH)
  ) u_rxfifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .full  (w_full),
    .empty (w_empty),
    .din   (w_byte),
    .dout  (w_dout)
  );

  assign miso      = r_miso;
  assign rx_data   = w_dout;
  assign rx_valid  = !w_empty;
  assign tx_ready  = (r_state == IDLE);
  assign busy      = (r_state == SHIFT);
  assign overflow  = r_overflow;
  assign frame_err = r_frame_err;

endmodule

// File: doc/spi_slave_fsm.md
SPI_SLAVE_FSM -- requirements
Module: spi_slave_fsm

Interface
REQ-001 Parameter: DATA_W, 8, frame width in bits (MSB first).
REQ-002 Parameter: FIFO_DEPTH, 4, receive FIFO entries (power of two; used only with SPI_SLV_FIFO_EN).
REQ-003 clk  input  1  single clock; every register SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ss  input  1  slave select, active-low, synchronous to clk.
REQ-006 mosi  input  1  serial data from initiator, one bit per clk while ss low.
REQ-007 miso  output  1  serial data to initiator, registered.
REQ-008 rx_data  output  DATA_W  received byte at FIFO/holding-register head.
REQ-009 rx_valid  output  1  rx_data valid; rx_ready  input  1  consumer accepts when rx_valid&rx_ready.
REQ-010 tx_data  input  DATA_W  reply byte; tx_valid  input  1; tx_ready  output  1  high when a reply can be loaded.
REQ-011 busy  output  1; overflow  output  1  sticky; frame_err  output  1  one-cycle pulse.

Function
REQ-012 States SHALL be IDLE and SHIFT; bit counter bit_cnt SHALL be 3 bits wide (log2 DATA_W), counting 0..DATA_W-1.
REQ-013 IDLE->SHIFT on first clk with ss==0; that same edge SHALL sample mosi as bit DATA_W-1.
REQ-014 In SHIFT, each clk with ss==0 SHALL sample mosi into the next lower bit and increment bit_cnt.
REQ-015 On the sample with bit_cnt==DATA_W-1 the assembled byte SHALL be written to the receive store the same edge; rx_valid SHALL rise the following cycle (latency 1 clk after last bit).
REQ-016 ss still low after a full byte: bit_cnt SHALL wrap to 0 and the next byte SHALL be received back-to-back with no gap cycle.
REQ-017 ss==1 in SHIFT with bit_cnt!=0: partial byte discarded, frame_err pulsed 1 cycle, ->IDLE.
REQ-018 ss==1 in SHIFT with bit_cnt==0 (byte boundary): ->IDLE, no error.
REQ-019 Byte completing while receive store full: byte dropped, overflow set until reset; stored data unchanged.
REQ-020 Completion and rx pop in same cycle while full: pop first, byte SHALL be stored, no overflow.
REQ-021 tx_ready SHALL be 1 in IDLE and 0 in SHIFT; tx_valid&tx_ready loads tx shift register.
REQ-022 In IDLE miso SHALL present tx_shift[DATA_W-1]; each sampled bit in SHIFT shifts tx_shift left and shifts 0 in at LSB.
REQ-023 No reply loaded for a frame: miso SHALL transmit 0x00 (tx_shift cleared after each completed byte).
REQ-024 busy SHALL equal (state==SHIFT).

Reset
REQ-025 reset SHALL force IDLE, bit_cnt=0, miso=0, rx_valid=0, rx_data=0, tx_shift=0, overflow=0, frame_err=0, busy=0, receive store empty.
REQ-026 reset mid-frame SHALL discard the partial byte and all stored bytes without frame_err.

Configuration
REQ-027 Macro SPI_SLV_FIFO_EN defined: receive store SHALL be a FIFO_DEPTH-entry FIFO with wrap-around pointers, full at FIFO_DEPTH entries.
REQ-028 Macro absent: receive store SHALL be a single holding register, full when rx_valid==1; all other behaviour identical.

Structure
REQ-029 Package spi_pkg SHALL hold DATA_W default, state encoding constants (IDLE=0, SHIFT=1) and FIFO_DEPTH default.
REQ-030 Receive store SHALL be sub-module spi_slv_rxfifo (depth 1 when macro absent), ports push/pop/full/empty/din/dout.

Verification
REQ-031 ss low 8 clks, mosi bits of 0xA5 -> rx_valid high cycle 9, rx_data=0xA5, frame_err=0.
REQ-032 tx_data=0x3C loaded in IDLE, 8-bit frame -> miso sequence 0,0,1,1,1,1,0,0; next frame without load -> 0x00.
REQ-033 ss low 16 clks, 0x12 then 0x34, rx_ready=1 -> two pops 0x12, 0x34, no gap, busy high 16 cycles.
REQ-034 ss high after 5 bits -> frame_err single pulse, no rx_valid, next full frame 0x81 received correctly.
REQ-035 rx_ready=0, send FIFO_DEPTH+1 bytes (1 byte without macro) -> last byte dropped, overflow=1 until reset, head unchanged.
REQ-036 reset asserted at bit 4 of frame -> all outputs at reset values next cycle, following frame 0xFF received intact.
